// File: rtl/booth_muldiv_seq.sv
// Sequential 32-bit signed multiply (radix-4 Booth) / divide (restoring) unit.
// Define MULDIV_DIV_UNIT_EN to build the divider; otherwise DIV commands are ignored.
module booth_muldiv_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [32:0] mplr;
    logic [4:0]  cnt;
    logic        idle_like;
    logic        accept;
    logic        busy_nx;
    logic        done_nx;
    logic [63:0] booth;

    assign idle_like = (state == S_IDLE) || (state == S_DONE);

`ifdef MULDIV_DIV_UNIT_EN
    logic        sign_a, sign_b;
    logic        dz;
    logic        dvz;
    logic [63:0] sh;
    logic [32:0] diff;
    logic [63:0] div_step;
    logic [31:0] abs_a, abs_b;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] a_raw;

    assign accept      = start && idle_like;
    assign div_by_zero = dz;
    assign dvz         = (mcand[31:0] == 32'h0);
    assign abs_a       = a[31] ? (32'h0 - a) : a;
    assign abs_b       = b[31] ? (32'h0 - b) : b;
    assign a_raw       = sign_a ? (32'h0 - acc[31:0]) : acc[31:0];
    assign quo_fix     = (sign_a ^ sign_b) ? (32'h0 - acc[31:0]) : acc[31:0];
    assign rem_fix     = sign_a ? (32'h0 - acc[63:32]) : acc[63:32];

    // Remainder never exceeds 2^31, so acc[63] is always clear before the shift
    always_comb begin
        sh       = {acc[62:0], 1'b0};
        diff     = {1'b0, sh[63:32]} - {1'b0, mcand[31:0]};
        div_step = diff[32] ? sh : {diff[31:0], sh[31:1], 1'b1};
    end
`else
    assign accept      = start && idle_like && !op;
    assign div_by_zero = 1'b0;
`endif

    always_comb begin
        booth = '0;
        unique case (mplr[2:0])
            3'b001, 3'b010: booth = mcand;
            3'b011:         booth = mcand << 1;
            3'b100:         booth = 64'h0 - (mcand << 1);
            3'b101, 3'b110: booth = 64'h0 - mcand;
            default:        booth = '0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (!accept) state_nx = S_IDLE;
`ifdef MULDIV_DIV_UNIT_EN
                else         state_nx = op ? S_DIV : S_MUL;
`else
                else         state_nx = S_MUL;
`endif
            end
            S_MUL: if (cnt == 5'd15) state_nx = S_DONE;
`ifdef MULDIV_DIV_UNIT_EN
            S_DIV: begin
                if (dvz)               state_nx = S_DONE;
                else if (cnt == 5'd31) state_nx = S_FIX;
            end
            S_FIX: state_nx = S_DONE;
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy_nx = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
        done_nx = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
`ifdef MULDIV_DIV_UNIT_EN
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz     <= 1'b0;
`endif
        end else begin
            busy <= busy_nx;
            done <= done_nx;
            if (state == S_DONE) begin
                hi <= acc[63:32];
                lo <= acc[31:0];
            end
            if (accept) begin
                cnt <= '0;
`ifdef MULDIV_DIV_UNIT_EN
                dz  <= 1'b0;
                if (op) begin
                    acc    <= {32'h0, abs_a};
                    mcand  <= {32'h0, abs_b};
                    mplr   <= '0;
                    sign_a <= a[31];
                    sign_b <= b[31];
                end else begin
                    acc   <= '0;
                    mcand <= {{32{a[31]}}, a};
                    mplr  <= {b, 1'b0};
                end
`else
                acc   <= '0;
                mcand <= {{32{a[31]}}, a};
                mplr  <= {b, 1'b0};
`endif
            end else begin
                unique case (state)
                    S_MUL: begin
                        acc   <= acc + booth;
                        mcand <= mcand << 2;
                        mplr  <= mplr >> 2;
                        cnt   <= cnt + 5'd1;
                    end
`ifdef MULDIV_DIV_UNIT_EN
                    S_DIV: begin
                        if (dvz) begin
                            acc <= {a_raw, 32'hFFFF_FFFF};
                            dz  <= 1'b1;
                        end else begin
                            acc <= div_step;
                            cnt <= cnt + 5'd1;
                        end
                    end
                    S_FIX: acc <= {rem_fix, quo_fix};
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_booth_muldiv_seq.sv
// Randomised self-checking bench for booth_muldiv_seq against a plain-arithmetic model.
// Honours MULDIV_DIV_UNIT_EN the same way the design does.
module tb_booth_muldiv_seq;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_pass = 0;

    booth_muldiv_seq dut (
        .clk(clk), .clr(clr), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {div_by_zero, hi, lo}
    function automatic logic [64:0] model(input logic o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint p, q, r;
        logic [63:0] pv, qv, rv;
        if (!o) begin
            p  = longint'($signed(x)) * longint'($signed(y));
            pv = p;
            return {1'b0, pv};
        end
        if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
        q  = longint'($signed(x)) / longint'($signed(y));
        r  = longint'($signed(x)) % longint'($signed(y));
        qv = q;
        rv = r;
        return {1'b0, rv[31:0], qv[31:0]};
    endfunction

    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
    endtask

    task automatic step(inout int lat, inout int bc);
        @(posedge clk); #1;
        lat++;
        if (busy) bc++;
    endtask

    task automatic wait_done(inout int lat, inout int bc);
        while (!done && lat < 80) step(lat, bc);
    endtask

    task automatic check_res(input string tag, input logic [64:0] e);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy@done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(e[63:32]));
        check({tag, " lo"}, 64'(lo), 64'(e[31:0]));
        check({tag, " dz"}, 64'(div_by_zero), 64'(e[64]));
    endtask

    task automatic run(input logic o, input logic [31:0] x, input logic [31:0] y,
                       input string tag);
        logic [64:0] e;
        int lat, bc, el;
        e   = model(o, x, y);
        el  = !o ? 17 : (y == 32'h0) ? 2 : 34;
        lat = 0;
        bc  = 0;
        issue(o, x, y);
        wait_done(lat, bc);
        check({tag, " lat"}, 64'(lat), 64'(el));
        check({tag, " busycnt"}, 64'(bc), 64'(el - 1));
        check_res(tag, e);
    endtask

    initial begin
        logic [64:0] e1, e2;
        logic [31:0] x, y;
        int lat, bc, seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst dz", 64'(div_by_zero), 64'd0);
        @(negedge clk) clr = 1'b1;

        run(1'b0, 32'd7, 32'hFFFF_FFFD, "mul7x-3");
        check("mul7x-3 hi const", 64'(hi), 64'hFFFF_FFFF);
        check("mul7x-3 lo const", 64'(lo), 64'hFFFF_FFEB);
        run(1'b0, 32'h8000_0000, 32'h8000_0000, "mulminmin");
        check("mulminmin hi const", 64'(hi), 64'h4000_0000);
        run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul-1x-1");
        check("mul-1x-1 lo const", 64'(lo), 64'd1);

`ifdef MULDIV_DIV_UNIT_EN
        run(1'b1, 32'hFFFF_FFEF, 32'd5, "div-17/5");
        check("div-17/5 lo const", 64'(lo), 64'hFFFF_FFFD);
        check("div-17/5 hi const", 64'(hi), 64'hFFFF_FFFE);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
        check("divovf lo const", 64'(lo), 64'h8000_0000);
        run(1'b1, 32'd42, 32'd0, "div42/0");
        check("div42/0 dz const", 64'(div_by_zero), 64'd1);
        run(1'b0, 32'd2, 32'd3, "mul2x3");
        check("mul2x3 lo const", 64'(lo), 64'd6);
`else
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy || done) seen++;
            @(posedge clk); #1;
        end
        check("div ignored busy/done", 64'(seen), 64'd0);
        check("div ignored hi", 64'(hi), 64'd0);
        check("div ignored lo", 64'(lo), 64'd1);
        run(1'b0, 32'd2, 32'd3, "mul2x3");
`endif

        // start pulsed while busy must be ignored
        e1  = model(1'b0, 32'd1234567, 32'hFFFF_FFA7);
        lat = 0;
        bc  = 0;
        issue(1'b0, 32'd1234567, 32'hFFFF_FFA7);
        repeat (5) step(lat, bc);
        @(negedge clk);
        start = 1'b1; op = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
        step(lat, bc);
        start = 1'b0;
        wait_done(lat, bc);
        check("ignbusy lat", 64'(lat), 64'd17);
        check_res("ignbusy", e1);

        // back-to-back: second command accepted in the DONE state
        x   = $urandom | 32'h1;
        y   = $urandom | 32'h1;
        e1  = model(1'b0, 32'h0012_3456, 32'h7654_3210);
        e2  = model(1'b0, x, y);
        lat = 0;
        bc  = 0;
        issue(1'b0, 32'h0012_3456, 32'h7654_3210);
        repeat (15) step(lat, bc);
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = x; b = y;
        step(lat, bc);
        check("b2b early done", 64'(done), 64'd0);
        step(lat, bc);
        start = 1'b0; a = $urandom; b = $urandom;
        check("b2b first lat", 64'(lat), 64'd17);
        check_res("b2b first", e1);
        lat = 0;
        bc  = 0;
        step(lat, bc);
        wait_done(lat, bc);
        check("b2b second lat", 64'(lat), 64'd17);
        check_res("b2b second", e2);

        // clr mid-multiply
        lat = 0;
        bc  = 0;
        issue(1'b0, 32'h0BAD_F00D, 32'h1357_9BDF);
        repeat (7) step(lat, bc);
        clr = 1'b0;
        #1;
        check("clr busy", 64'(busy), 64'd0);
        check("clr done", 64'(done), 64'd0);
        check("clr hi", 64'(hi), 64'd0);
        check("clr lo", 64'(lo), 64'd0);
        check("clr dz", 64'(div_by_zero), 64'd0);
        @(negedge clk) clr = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("clr no done", 64'(seen), 64'd0);
        run(1'b0, 32'hFFFF_0001, 32'd99999, "postclr");

        for (int i = 0; i < 12; i++) begin
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) y = 32'h0 - y;
            run(1'b0, x, y, "rndmul");
        end
`ifdef MULDIV_DIV_UNIT_EN
        for (int i = 0; i < 12; i++) begin
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) y = 32'h0 - y;
            if ($urandom_range(0, 5) == 0) y = 32'h0;
            run(1'b1, x, y, "rnddiv");
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/booth_muldiv_seq.md
# booth_muldiv_seq

Multi-cycle sequencer for the CPU's 32-bit multiply/divide path. Accepts one signed MUL or DIV command at a time, iterates a shared 64-bit accumulator (radix-4 Booth for multiply, restoring shift-subtract for divide) and writes the result to HI/LO for the register file. Sits beside the single-cycle ALU. The datapath FSM holds the CPU in its execute step while `busy` is high.

## Interface
- No parameters. Width is fixed at 32 bits.
- `clk`  in  1  system clock, rising-edge active
- `clr`  in  1  asynchronous, active-low reset
- `start`  in  1  command request; sampled only while idle
- `op`  in  1  0 = signed MUL, 1 = signed DIV
- `a`  in  32  multiplicand / dividend (two's complement)
- `b`  in  32  multiplier / divisor (two's complement)
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse; HI/LO valid
- `hi`  out  32  MUL: product[63:32]; DIV: remainder
- `lo`  out  32  MUL: product[31:0]; DIV: quotient
- `div_by_zero`  out  1  sticky flag for the last DIV command; cleared when the next command is accepted

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE: when `start`=1, latch `a`, `b` and `op`. Go to MUL (op=0) or DIV (op=1).
- `start` is ignored in every state except IDLE and DONE. No queueing.
- MUL, 16 iterations:
  - Each iteration examines the Booth triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Triplet weights: 000/111 → 0, 001/010 → +A, 011 → +2A, 100 → −2A, 101/110 → −A.
  - The selected term is sign-extended to 64 bits, shifted left by 2i and added to the accumulator.
  - After iteration 15, go to DONE.
- DIV:
  - If b=0: skip iteration. Set `div_by_zero`=1, hi=a, lo=32'hFFFF_FFFF, go to DONE.
  - Otherwise: take unsigned magnitudes |a| and |b|, with |−2^31| = 32'h8000_0000.
  - Run 32 restoring iterations: shift the remainder:quotient pair left by 1, trial-subtract |b|, keep the result if non-negative and set the quotient bit.
  - Then go to FIX.
- FIX:
  - Negate the quotient if sign(a)≠sign(b).
  - Negate the remainder if a<0. The remainder takes the sign of the dividend; the quotient truncates toward zero.
  - Go to DONE.
- Overflow case −2^31 / −1 gives lo=32'h8000_0000, hi=0, with no flag.
- DONE:
  - Assert `done` for one cycle and write hi/lo.
  - If `start`=1 in this state, accept the new command (back-to-back). Otherwise go to IDLE.
- hi/lo hold their values until the next DONE. They are not disturbed by iteration.

## Timing
- Let cycle N be the rising edge that accepts `start`.
- MUL: `busy`=1 from N+1 through N+16. `done`=1 and hi/lo valid at N+17. Latency 17.
- DIV, b≠0: `busy`=1 from N+1 through N+33 (32 iterations plus FIX). `done` at N+34.
- DIV, b=0: `done` at N+2.
- `busy`=0 in the DONE cycle and in IDLE.
- Reset values: `busy`=0, `done`=0, hi=0, lo=0, `div_by_zero`=0, state IDLE, accumulator=0.
- Asserting `clr` mid-operation aborts the command at once and returns all outputs to their reset values. No `done` is produced.
- Operand changes on `a`/`b`/`op` after cycle N have no effect on the result.

## Configuration
- Macro: `MULDIV_DIV_UNIT_EN`.
- Defined: full behaviour as above.
- Undefined:
  - DIV, FIX and the divide adder/magnitude logic are not built.
  - `start` with op=1 is ignored: no `busy`, no `done`, HI/LO unchanged.
  - `div_by_zero` is tied to 0.
  - MUL behaviour and timing are unchanged.

## Test plan
- MUL a=7, b=−3 → hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB, `done` exactly 17 cycles after accept; `busy` high for 16 cycles.
- MUL a=b=32'h8000_0000 → hi=32'h4000_0000, lo=0. Also MUL a=32'hFFFF_FFFF, b=32'hFFFF_FFFF → hi=0, lo=1.
- DIV a=−17, b=5 → lo=32'hFFFF_FFFD (−3), hi=32'hFFFF_FFFE (−2), `done` at N+34. Then DIV a=32'h8000_0000, b=−1 → lo=32'h8000_0000, hi=0.
- DIV a=42, b=0 → `done` at N+2, `div_by_zero`=1, hi=42, lo=32'hFFFF_FFFF. The following MUL 2×3 clears the flag and gives lo=6.
- Pulse `start` while busy with a different operand → ignored, first result intact. Back-to-back MUL issued in the DONE cycle → second `done` 17 cycles later.
- Assert `clr` at N+8 of a MUL → outputs zero immediately, no `done`. A fresh MUL after release completes normally.
- Build without `MULDIV_DIV_UNIT_EN` → DIV `start` ignored (`busy` stays 0 for 40 cycles). MUL results match the defined build.
